// File: rtl/dice_lights_sched_if.sv
// Button, dice/lights feedback and display bundle for dice_lights_sched.
// master drives the button and feedback inputs; slave is the scheduler.
interface dice_lights_sched_if;
    logic       button;
    logic [2:0] throw;
    logic [2:0] colour;
    logic       dice_button;
    logic       lights_step;
    logic       sel;
    logic [2:0] result;
    logic       busy;

    modport master (
        output button,
        output throw,
        output colour,
        input  dice_button,
        input  lights_step,
        input  sel,
        input  result,
        input  busy
    );

    modport slave (
        input  button,
        input  throw,
        input  colour,
        output dice_button,
        output lights_step,
        output sel,
        output result,
        output busy
    );
endinterface

// File: rtl/dice_lights_sched.sv
// Display scheduler: lights cadence, dice roll/hold sequencing, display mux.
// Define DICE_ROLL_MIN_EN to enforce a minimum ROLL length of ROLL_MIN cycles.
module dice_lights_sched #(
    parameter int LIGHT_PERIOD = 4,
    parameter int HOLD_CYCLES  = 8,
    parameter int ROLL_MIN     = 3
) (
    input logic                clk,
    input logic                rst,
    dice_lights_sched_if.slave bus
);
    localparam int LW = (LIGHT_PERIOD > 1) ? $clog2(LIGHT_PERIOD) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [LW-1:0] LIGHT_LAST = LW'(LIGHT_PERIOD - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

    generate
        if (LIGHT_PERIOD < 2) begin : g_bad_light_period
            $error("dice_lights_sched: LIGHT_PERIOD must be at least 2");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
            $error("dice_lights_sched: HOLD_CYCLES must be at least 1");
        end
        if (ROLL_MIN < 1) begin : g_bad_roll_min
            $error("dice_lights_sched: ROLL_MIN must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        LIGHTS = 2'b00,
        ROLL   = 2'b01,
        HOLD   = 2'b10
    } state_t;

    state_t        state;
    logic [LW-1:0] light_cnt;
    logic [HW-1:0] hold_cnt;
    logic          dice_button;
    logic          lights_step;
    logic          sel;
    logic          busy;
    logic [2:0]    result;
    logic          release_ok;
    logic [2:0]    shown_throw;

`ifdef DICE_ROLL_MIN_EN
    localparam int RW = (ROLL_MIN > 1) ? $clog2(ROLL_MIN) : 1;
    localparam logic [RW-1:0] ROLL_LAST = RW'(ROLL_MIN - 1);

    logic [RW-1:0] roll_cnt;

    // Cycles spent in ROLL, saturating once the minimum is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            roll_cnt <= '0;
        end else if (state != ROLL) begin
            roll_cnt <= '0;
        end else if (roll_cnt != ROLL_LAST) begin
            roll_cnt <= roll_cnt + 1'b1;
        end
    end

    // An early release is held off until the roll has lasted long enough.
    assign release_ok = !bus.button && (roll_cnt >= ROLL_LAST);
`else
    assign release_ok = !bus.button;
`endif

    // Die faces only run 1..6; the two unused codes show as a one.
    assign shown_throw = (bus.throw == 3'd0 || bus.throw == 3'd7)
                       ? 3'd1 : bus.throw;

    // Scheduler FSM; outputs are registered from the next state (Moore).
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LIGHTS;
            light_cnt   <= '0;
            hold_cnt    <= '0;
            dice_button <= 1'b0;
            lights_step <= 1'b0;
            sel         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            lights_step <= 1'b0;
            case (state)
                LIGHTS: begin
                    // The cadence keeps running even on the press cycle.
                    if (light_cnt == LIGHT_LAST) begin
                        light_cnt   <= '0;
                        lights_step <= 1'b1;
                    end else begin
                        light_cnt <= light_cnt + 1'b1;
                    end
                    if (bus.button) begin
                        state       <= ROLL;
                        hold_cnt    <= '0;
                        dice_button <= 1'b1;
                        sel         <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ROLL: begin
                    hold_cnt <= '0;
                    if (release_ok) begin
                        state       <= HOLD;
                        dice_button <= 1'b0;
                    end
                end
                HOLD: begin
                    // The button is deliberately not looked at here.
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= LIGHTS;
                        hold_cnt <= '0;
                        sel      <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= LIGHTS;
                    hold_cnt    <= '0;
                    dice_button <= 1'b0;
                    sel         <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // Display register: one cycle behind the mux select and its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= 3'd0;
        end else if (sel) begin
            result <= shown_throw;
        end else begin
            result <= bus.colour;
        end
    end

    assign bus.dice_button = dice_button;
    assign bus.lights_step = lights_step;
    assign bus.sel         = sel;
    assign bus.busy        = busy;
    assign bus.result      = result;
endmodule

// File: tb/tb_dice_lights_sched.sv
// Scoreboard bench for dice_lights_sched: stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_dice_lights_sched;
    localparam int LP = 4;
    localparam int HC = 8;
    localparam int RM = 3;
`ifdef DICE_ROLL_MIN_EN
    localparam int R = RM;
`else
    localparam int R = 1;
`endif

    typedef struct {
        int         cyc;
        string      name;
        logic [6:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];
    exp_t mon_e;
    logic [6:0] mon_act;

    logic [2:0] th2 [14] = '{3'd3, 3'd7, 3'd5, 3'd0, 3'd6, 3'd2, 3'd7,
                             3'd3, 3'd4, 3'd5, 3'd1, 3'd0, 3'd6, 3'd5};
    logic [2:0] rs2 [14] = '{3'd2, 3'd1, 3'd5, 3'd1, 3'd6, 3'd2, 3'd1,
                             3'd3, 3'd4, 3'd5, 3'd1, 3'd1, 3'd6, 3'd5};

    dice_lights_sched_if bus ();

    dice_lights_sched #(
        .LIGHT_PERIOD(LP),
        .HOLD_CYCLES (HC),
        .ROLL_MIN    (RM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due at or before this cycle.
    always @(negedge clk) begin
        mon_act = {bus.dice_button, bus.lights_step, bus.sel,
                   bus.busy, bus.result};
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            mon_e = sbq.pop_front();
            checks++;
            if (mon_e.cyc != cyc || mon_act !== mon_e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d {db,ls,sel,busy,res} got=%b want=%b",
                         mon_e.name, cyc, mon_act, mon_e.exp);
            end
        end
    end

    // Drive inputs for the next edge and queue the outputs expected after it.
    task automatic step(input logic b, input logic [2:0] t,
                        input logic [2:0] c, input logic db,
                        input logic ls, input logic sl,
                        input logic [2:0] res, input string name);
        exp_t e;
        bus.button = b;
        bus.throw  = t;
        bus.colour = c;
        @(posedge clk);
        #1;
        e.cyc  = cyc;
        e.name = name;
        e.exp  = {db, ls, sl, sl, res};
        sbq.push_back(e);
    endtask

    initial begin
        logic prev;
        logic sl;
        bus.button = 1'b0;
        bus.throw  = 3'd0;
        bus.colour = 3'd0;
        rst = 1'b1;
        step(0, 3'd5, 3'd6, 0, 0, 0, 3'd0, "reset");
        step(0, 3'd5, 3'd6, 0, 0, 0, 3'd0, "reset_hold");
        rst = 1'b0;

        for (int k = 1; k <= 20; k++)
            step(0, 3'd0, 3'(k % 8), 0, (k % 4 == 0), 0, 3'(k % 8),
                 "lights_cadence");

        for (int i = 0; i < 14; i++)
            step(i < 5, th2[i], 3'd2, i < 5, 0, i < 13, rs2[i],
                 "roll5_hold8");

        for (int j = 1; j <= 4; j++)
            step(0, 3'd0, 3'b100, 0, j == 3, 0, 3'b100, "lights_resume");

        step(1, 3'd5, 3'd3, 1, 0, 1, 3'd3, "pulse_press");
        for (int j = 1; j <= R + 8; j++)
            step(0, 3'd5, 3'd3, j < R, 0, j < R + 8, 3'd5, "pulse_seq");
        step(0, 3'd5, 3'd3, 0, 0, 0, 3'd3, "pulse_ret1");
        step(0, 3'd5, 3'd3, 0, 1, 0, 3'd3, "pulse_ret2");

        step(1, 3'd4, 3'd6, 1, 0, 1, 3'd6, "repress");
        prev = 1'b1;
        for (int j = 1; j <= R + 9; j++) begin
            sl = (j <= R + 7) || (j == R + 9);
            step(j >= R + 1, 3'd4, 3'd6, (j < R) || (j == R + 9), 0, sl,
                 prev ? 3'd4 : 3'd6, "hold_lockout");
            prev = sl;
        end

        for (int j = 1; j <= R + 2; j++)
            step(0, 3'd4, 3'd6, j < R, 0, 1, 3'd4, "pre_reset");
        rst = 1'b1;
        step(0, 3'd4, 3'd6, 0, 0, 0, 3'd0, "reset_mid_hold");
        rst = 1'b0;
        for (int k = 1; k <= 5; k++)
            step(0, 3'd4, 3'd6, 0, k == 4, 0, 3'd6, "post_reset");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
